// File: rtl/mdu_unit.sv
// Multiply/divide unit beside the EX stage. Owns HI/LO and models a fixed
// multi-cycle latency with a busy flag; the result is computed at the start
// edge, held in shadow registers and committed to HI/LO at completion.
module mdu_unit #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  mdu_op,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CntW      = $clog2(MaxCycles + 1);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [31:0]     hi_q, hi_d, lo_q, lo_d;
  logic [31:0]     sh_hi_q, sh_hi_d, sh_lo_q, sh_lo_d;
  logic            sh_wr_q, sh_wr_d;

  logic [63:0] prod_s, prod_u;
  logic [31:0] a_mag, b_mag, q_mag, r_mag, q_s, r_s, q_u, r_u, divisor_u;
  logic        div_zero;

  // Combinational arithmetic on the live operands; sampled only at the start edge.
  always_comb begin
    prod_s    = $signed({{32{rs_data[31]}}, rs_data}) * $signed({{32{rt_data[31]}}, rt_data});
    prod_u    = {32'd0, rs_data} * {32'd0, rt_data};
    div_zero  = (rt_data == 32'd0);
    // Divisor forced to 1 on zero so the dividers never see 0; the result is discarded anyway.
    divisor_u = div_zero ? 32'd1 : rt_data;
    q_u       = rs_data / divisor_u;
    r_u       = rs_data % divisor_u;
    // Signed divide through magnitudes: avoids the INT_MIN / -1 overflow case entirely.
    a_mag     = rs_data[31] ? -rs_data : rs_data;
    b_mag     = div_zero ? 32'd1 : (rt_data[31] ? -rt_data : rt_data);
    q_mag     = a_mag / b_mag;
    r_mag     = a_mag % b_mag;
    q_s       = (rs_data[31] ^ rt_data[31]) ? -q_mag : q_mag;
    r_s       = rs_data[31] ? -r_mag : r_mag;
  end

  // Next-state: op launch / MTHI / MTLO from idle, countdown and commit while running.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    sh_hi_d = sh_hi_q;
    sh_lo_d = sh_lo_q;
    sh_wr_d = sh_wr_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          case (mdu_op)
            3'd0: begin
              sh_hi_d = prod_s[63:32];
              sh_lo_d = prod_s[31:0];
              sh_wr_d = 1'b1;
              cnt_d   = CntW'(MULT_CYCLES);
              state_d = StRun;
            end
            3'd1: begin
              sh_hi_d = prod_u[63:32];
              sh_lo_d = prod_u[31:0];
              sh_wr_d = 1'b1;
              cnt_d   = CntW'(MULT_CYCLES);
              state_d = StRun;
            end
            3'd2: begin
              sh_hi_d = r_s;
              sh_lo_d = q_s;
              sh_wr_d = !div_zero;
              cnt_d   = CntW'(DIV_CYCLES);
              state_d = StRun;
            end
            3'd3: begin
              sh_hi_d = r_u;
              sh_lo_d = q_u;
              sh_wr_d = !div_zero;
              cnt_d   = CntW'(DIV_CYCLES);
              state_d = StRun;
            end
            3'd4:    hi_d = rs_data;
            3'd5:    lo_d = rs_data;
            default: ;
          endcase
        end
      end
      StRun: begin
        if (cnt_q == CntW'(1)) begin
          cnt_d   = '0;
          state_d = StIdle;
          if (sh_wr_q) begin
            hi_d = sh_hi_q;
            lo_d = sh_lo_q;
          end
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers; reset aborts any operation in flight without committing.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      sh_hi_q <= '0;
      sh_lo_q <= '0;
      sh_wr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      sh_hi_q <= sh_hi_d;
      sh_lo_q <= sh_lo_d;
      sh_wr_q <= sh_wr_d;
    end
  end

  assign busy = (state_q == StRun);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mdu_unit.sv
// Bench for mdu_unit: directed cases with literal expectations plus randomized
// traffic, all checked every cycle against a transaction-level model.
module tb_mdu_unit;

  localparam int MultN = 5;
  localparam int DivN  = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  mdu_op = 3'd0;
  logic [31:0] rs_data = 32'd0;
  logic [31:0] rt_data = 32'd0;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  mdu_unit #(
    .MULT_CYCLES(MultN),
    .DIV_CYCLES (DivN)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .mdu_op (mdu_op),
    .rs_data(rs_data),
    .rt_data(rt_data),
    .busy   (busy),
    .hi     (hi),
    .lo     (lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Reference result of one op: {write_enable, hi, lo}, from plain 64-bit arithmetic.
  function automatic logic [64:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    longint sa, sb, ua, ub, r, q, m;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    r = 0;
    q = 0;
    m = 0;
    case (op)
      3'd0: begin r = sa * sb; return {1'b1, r[63:32], r[31:0]}; end
      3'd1: begin r = ua * ub; return {1'b1, r[63:32], r[31:0]}; end
      3'd2: begin
        if (b == 32'd0) return {1'b0, 64'd0};
        q = sa / sb;
        m = sa % sb;
        return {1'b1, m[31:0], q[31:0]};
      end
      3'd3: begin
        if (b == 32'd0) return {1'b0, 64'd0};
        q = ua / ub;
        m = ua % ub;
        return {1'b1, m[31:0], q[31:0]};
      end
      default: return {1'b0, 64'd0};
    endcase
  endfunction

  // Model: cycles left in flight plus the pending result.
  logic [31:0] m_hi = 32'd0, m_lo = 32'd0;
  int          m_left = 0;
  logic [64:0] m_pend = 65'd0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_hi   <= 32'd0;
      m_lo   <= 32'd0;
      m_left <= 0;
    end else if (m_left > 0) begin
      m_left <= m_left - 1;
      if (m_left == 1 && m_pend[64]) begin
        m_hi <= m_pend[63:32];
        m_lo <= m_pend[31:0];
      end
    end else if (start) begin
      case (mdu_op)
        3'd0, 3'd1: begin m_pend <= ref_result(mdu_op, rs_data, rt_data); m_left <= MultN; end
        3'd2, 3'd3: begin m_pend <= ref_result(mdu_op, rs_data, rt_data); m_left <= DivN; end
        3'd4: m_hi <= rs_data;
        3'd5: m_lo <= rs_data;
        default: ;
      endcase
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc_busy", 32'(busy), 32'(m_left > 0));
      chk("cyc_hi", hi, m_hi);
      chk("cyc_lo", lo, m_lo);
    end
  end

  // Issue one op for one cycle, scramble operands afterwards, count busy cycles.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int n);
    @(negedge clk);
    start = 1'b1;
    mdu_op = op;
    rs_data = a;
    rt_data = b;
    @(negedge clk);
    start = 1'b0;
    rs_data = $urandom;
    rt_data = $urandom;
    n = 0;
    while (busy && n < 40) begin
      n++;
      @(negedge clk);
    end
    if (n >= 40) begin
      total++;
      bad++;
      $display("FAIL busy_timeout: got busy after %0d cycles want idle", n);
    end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h8000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'd0;
      3: return 32'(($urandom_range(0, 20)));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int n;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    reset = 1'b0;
    chk_en = 1'b1;

    // Reset mid-DIV aborts immediately and never writes later.
    run_op(3'd4, 32'hDEAD_0001, 32'd0, n);
    run_op(3'd5, 32'hDEAD_0002, 32'd0, n);
    @(negedge clk);
    start = 1'b1; mdu_op = 3'd2; rs_data = 32'd100; rt_data = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_hi", hi, 32'd0);
    chk("abort_lo", lo, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (15) @(negedge clk);
    chk("abort_late_hi", hi, 32'd0);
    chk("abort_late_lo", lo, 32'd0);

    run_op(3'd0, 32'hFFFF_FFFE, 32'd3, n);
    chk("mult_cycles", n, 32'd5);
    chk("mult_hi", hi, 32'hFFFF_FFFF);
    chk("mult_lo", lo, 32'hFFFF_FFFA);

    run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, n);
    chk("multu_cycles", n, 32'd5);
    chk("multu_hi", hi, 32'hFFFF_FFFE);
    chk("multu_lo", lo, 32'h0000_0001);

    run_op(3'd2, 32'hFFFF_FFF9, 32'd2, n);
    chk("div_cycles", n, 32'd10);
    chk("div_lo", lo, 32'hFFFF_FFFD);
    chk("div_hi", hi, 32'hFFFF_FFFF);

    run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, n);
    chk("divovf_lo", lo, 32'h8000_0000);
    chk("divovf_hi", hi, 32'd0);

    run_op(3'd4, 32'h1234_5678, 32'd0, n);
    chk("mthi_cycles", n, 32'd0);
    run_op(3'd5, 32'h1234_5678, 32'd0, n);
    run_op(3'd3, 32'd5, 32'd0, n);
    chk("divz_cycles", n, 32'd10);
    chk("divz_hi", hi, 32'h1234_5678);
    chk("divz_lo", lo, 32'h1234_5678);

    // MTLO issued while a MULT is in flight must be ignored.
    @(negedge clk);
    start = 1'b1; mdu_op = 3'd0; rs_data = 32'd7; rt_data = 32'd6;
    @(negedge clk);
    start = 1'b1; mdu_op = 3'd5; rs_data = 32'hAA;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (busy && n < 40) begin
      n++;
      @(negedge clk);
    end
    chk("ovl_cycles", n, 32'd4);
    chk("ovl_hi", hi, 32'd0);
    chk("ovl_lo", lo, 32'd42);

    run_op(3'd6, 32'h5555_5555, 32'd1, n);
    run_op(3'd7, 32'h6666_6666, 32'd1, n);
    chk("nop_busy", n, 32'd0);
    chk("nop_hi", hi, 32'd0);
    chk("nop_lo", lo, 32'd42);

    // Random traffic, including starts while busy and zero divisors.
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      start   = ($urandom_range(0, 2) == 0);
      mdu_op  = 3'($urandom_range(0, 7));
      rs_data = pick();
      rt_data = pick();
    end
    @(negedge clk);
    start = 1'b0;
    repeat (DivN + 2) @(negedge clk);
    chk("end_idle", 32'(busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
